// File: rtl/hockey_pkg.sv
// Shared types and constants for the hockey match controller.
package hockey_pkg;

    // Phase codes; the numeric values are visible on the phase output.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDisp  = 3'd1,
        StServe = 3'd2,
        StPlay  = 3'd3,
        StGoal  = 3'd4,
        StOver  = 3'd5
    } phase_e;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    // Increment a score, holding it once it reaches the limit.
    function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] lim);
        return (v < lim) ? v + 2'd1 : v;
    endfunction

endpackage

// File: rtl/hockey_match_ctrl_if.sv
// Button, puck-engine and scoreboard signals of the match controller.
interface hockey_match_ctrl_if;
    import hockey_pkg::*;

    logic       btn_a;
    logic       btn_b;
    logic       eng_ready;
    logic       eng_done;
    logic       eng_winner;
    logic       serve_go;
    logic       serve_side;
    logic [1:0] score_a;
    logic [1:0] score_b;
    phase_e     phase;
    logic       match_over;
    logic       winner;

    // Environment side: buttons and engine drive, scoreboard observes.
    modport master (
        output btn_a, btn_b, eng_ready, eng_done, eng_winner,
        input  serve_go, serve_side, score_a, score_b, phase, match_over, winner
    );

    // Controller side.
    modport slave (
        input  btn_a, btn_b, eng_ready, eng_done, eng_winner,
        output serve_go, serve_side, score_a, score_b, phase, match_over, winner
    );

endinterface

// File: rtl/hockey_phase_timer.sv
// 8-bit loadable down-counter timing the DISP and GOAL phases.
module hockey_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_en,
    output logic       o_tc
);

    logic [7:0] r_cnt;

    // Load takes priority; counting stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_tc = (r_cnt == 8'd0);

endmodule

// File: rtl/hockey_match_ctrl.sv
// Match sequencer: serve selection, display/goal pauses, scoring and match end.
module hockey_match_ctrl
    import hockey_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 3,
    parameter int unsigned DISP_CYCLES = 2,
    parameter int unsigned GOAL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    hockey_match_ctrl_if.slave io_bus
);

    localparam logic [1:0] WinScore = 2'(WIN_SCORE);
    // Timer is loaded with N-1 on entry so the phase lasts exactly N cycles.
    localparam logic [7:0] DispLoad = 8'(DISP_CYCLES - 1);
    localparam logic [7:0] GoalLoad = 8'(GOAL_CYCLES - 1);

    phase_e     r_state, w_state;
    logic       r_side, w_side;
    logic       r_go, w_go;
    logic [1:0] r_score_a, w_score_a;
    logic [1:0] r_score_b, w_score_b;
    logic       r_over, w_over;
    logic       r_winner, w_winner;

    logic       w_tmr_load;
    logic [7:0] w_tmr_val;
    logic       w_tmr_en;
    logic       w_tmr_tc;

    hockey_phase_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_tc       (w_tmr_tc)
    );

    // Next-state, score and timer control.
    always_comb begin
        w_state    = r_state;
        w_side     = r_side;
        w_go       = 1'b0;
        w_score_a  = r_score_a;
        w_score_b  = r_score_b;
        w_over     = r_over;
        w_winner   = r_winner;
        w_tmr_load = 1'b0;
        w_tmr_val  = 8'd0;
        w_tmr_en   = 1'b0;

        case (r_state)
            StIdle: begin
                if (io_bus.btn_a ^ io_bus.btn_b) begin
                    w_state    = StDisp;
                    w_side     = io_bus.btn_b ? SIDE_B : SIDE_A;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = DispLoad;
                end
            end
            StDisp: begin
                if (w_tmr_tc) begin
                    w_state = StServe;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            StServe: begin
                if (io_bus.eng_ready) begin
                    w_go    = 1'b1;
                    w_state = StPlay;
                end
            end
            StPlay: begin
                if (io_bus.eng_done) begin
                    if (io_bus.eng_winner == SIDE_B) begin
                        w_score_b = sat_inc(r_score_b, WinScore);
                    end else begin
                        w_score_a = sat_inc(r_score_a, WinScore);
                    end
                    // The player who conceded serves next.
                    w_side     = ~io_bus.eng_winner;
                    w_state    = StGoal;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = GoalLoad;
                end
            end
            StGoal: begin
                if (w_tmr_tc) begin
                    if ((r_score_a == WinScore) || (r_score_b == WinScore)) begin
                        w_state  = StOver;
                        w_over   = 1'b1;
                        w_winner = (r_score_b == WinScore) ? SIDE_B : SIDE_A;
                    end else begin
                        w_state = StServe;
                    end
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            StOver: begin
                w_state = StOver;
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_side    <= SIDE_A;
            r_go      <= 1'b0;
            r_score_a <= 2'd0;
            r_score_b <= 2'd0;
            r_over    <= 1'b0;
            r_winner  <= SIDE_A;
        end else begin
            r_state   <= w_state;
            r_side    <= w_side;
            r_go      <= w_go;
            r_score_a <= w_score_a;
            r_score_b <= w_score_b;
            r_over    <= w_over;
            r_winner  <= w_winner;
        end
    end

    assign io_bus.phase      = r_state;
    assign io_bus.serve_side = r_side;
    assign io_bus.serve_go   = r_go;
    assign io_bus.score_a    = r_score_a;
    assign io_bus.score_b    = r_score_b;
    assign io_bus.match_over = r_over;
    assign io_bus.winner     = r_winner;

endmodule

// File: doc/hockey_match_ctrl.md
HOCKEY_MATCH_CTRL -- requirements
Module: hockey_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 3, points needed to win the match (legal range 1..3).
REQ-002 SHALL have parameter DISP_CYCLES, default 2, length in cycles of the pre-serve display phase (legal range 1..255).
REQ-003 SHALL have parameter GOAL_CYCLES, default 2, length in cycles of the goal display phase (legal range 1..255).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port btn_a, input, 1, player A serve request (synchronised level).
REQ-007 SHALL have port btn_b, input, 1, player B serve request (synchronised level).
REQ-008 SHALL have port eng_ready, input, 1, puck engine idle and able to accept a serve.
REQ-009 SHALL have port eng_done, input, 1, single-cycle pulse marking the end of a point.
REQ-010 SHALL have port eng_winner, input, 1, scorer of the point (0=A, 1=B), valid only with eng_done.
REQ-011 SHALL have port serve_go, output, 1, single-cycle serve command to the engine.
REQ-012 SHALL have port serve_side, output, 1, serving player (0=A, 1=B), stable outside IDLE.
REQ-013 SHALL have port score_a, output, 2, player A score.
REQ-014 SHALL have port score_b, output, 2, player B score.
REQ-015 SHALL have port phase, output, 3, current state code.
REQ-016 SHALL have port match_over, output, 1, match finished.
REQ-017 SHALL have port winner, output, 1, match winner (0=A, 1=B), valid while match_over=1.

Function
REQ-018 SHALL implement states IDLE=0, DISP=1, SERVE=2, PLAY=3, GOAL=4 and OVER=5, with phase equal to the registered state code.
REQ-019 IDLE SHALL move to DISP when exactly one button is high, setting serve_side to the side whose button is pressed (btn_a only gives 0, btn_b only gives 1).
REQ-020 IDLE SHALL stay in IDLE when both buttons are high or neither is high.
REQ-021 DISP SHALL last exactly DISP_CYCLES cycles, then move to SERVE.
REQ-022 SERVE SHALL hold until eng_ready=1; in the cycle eng_ready is sampled high it SHALL assert serve_go for exactly one cycle and move to PLAY.
REQ-023 PLAY SHALL wait for eng_done; on eng_done it SHALL increment the scorer's score by 1, set serve_side to the non-scorer, and move to GOAL.
REQ-024 eng_done seen in any state other than PLAY SHALL be ignored: no score change, no state change.
REQ-025 PLAY entered in the cycle after serve_go SHALL still accept eng_done on its first cycle.
REQ-026 GOAL SHALL last exactly GOAL_CYCLES cycles, then move to OVER if either score equals WIN_SCORE, otherwise to SERVE (skipping DISP).
REQ-027 OVER SHALL be absorbing: match_over=1, winner equal to the side whose score equals WIN_SCORE, all buttons and engine inputs ignored.
REQ-028 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-029 Button presses in DISP, SERVE, PLAY or GOAL SHALL have no effect.
REQ-030 serve_go SHALL never assert outside the SERVE-to-PLAY transition cycle.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 On rst: state=IDLE, serve_side=0, serve_go=0, score_a=0, score_b=0, match_over=0, winner=0, phase timer=0.
REQ-033 Reset asserted mid-operation (any state, including PLAY) SHALL abort immediately to the reset values, with no serve_go or score glitch on release.
REQ-034 The first rising clock edge after rst deasserts SHALL evaluate IDLE normally.

Structure
REQ-035 Package hockey_pkg SHALL hold the phase state codes and the side constants SIDE_A=0 and SIDE_B=1.
REQ-036 SHALL instantiate one sub-module, hockey_phase_timer: an 8-bit loadable down-counter with a load input and a terminal-count output, shared by DISP and GOAL.

Verification
REQ-037 Reset, then btn_a=1 for 1 cycle, eng_ready=1 -> phase sequence 0,1,1,2,3 (DISP_CYCLES=2); serve_go high exactly 1 cycle; serve_side=0.
REQ-038 btn_a=btn_b=1 for 5 cycles, then btn_b alone -> phase stays 0 during the tie; then DISP entered with serve_side=1.
REQ-039 In PLAY, eng_done with eng_winner=0 -> score_a 0 to 1, serve_side=1, GOAL held 2 cycles, then SERVE.
REQ-040 A wins 3 points -> score_a=3, phase=5, match_over=1, winner=0; further eng_done pulses and buttons leave all outputs unchanged.
REQ-041 eng_done pulsed during DISP and during SERVE with eng_ready=0 -> scores unchanged, no state change; serve_go withheld until eng_ready=1.
REQ-042 rst asserted in PLAY with score_b=2 -> all outputs return to reset values asynchronously, and phase=0 after release.
